// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rr_arb.sv
// Round-robin arbiter whose one-hot grant bits drive the enable inputs of per-requester and2 gates.
// One dead cycle separates consecutive grants so the gated enables never overlap.
module gf180mcu_fd_sc_mcu7t5v0__rr_arb #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  output logic [N-1:0] GNT,
  output logic [2:0]   GNT_ID,
  output logic         BUSY,
  inout  wire          VDD,
  inout  wire          VSS
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t         r_state, w_state_nx;
  logic [N-1:0]   r_gnt, w_gnt_nx;
  logic [IW-1:0]  r_id, w_id_nx;
  logic [IW-1:0]  r_ptr, w_ptr_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic           r_busy;
  logic           w_sel_vld;
  logic [IW-1:0]  w_sel;
  logic           w_release;
  logic           w_pwr_ok;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int t;
    t = int'(a) + b;
    if (t >= N) t = t - N;
    return IW'(t);
  endfunction

  // Search downward so the requester closest to the pointer wins.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (REQ[wrap_add(r_ptr, k)] == 1'b1) begin
        w_sel_vld = 1'b1;
        w_sel     = wrap_add(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_id_nx    = r_id;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_release  = (REQ[r_id] != 1'b1) ||
                 ((MAX_HOLD != 0) && (r_cnt == CW'(MAX_HOLD)));
    case (r_state)
      S_IDLE, S_GAP: begin
        w_gnt_nx = '0;
        if (w_sel_vld) begin
          w_state_nx = S_GRANT;
          w_gnt_nx   = N'(1) << w_sel;
          w_id_nx    = w_sel;
          w_cnt_nx   = CW'(1);
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nx = S_GAP;
          w_gnt_nx   = '0;
          w_ptr_nx   = wrap_add(r_id, 1);
        end else if (!((MAX_HOLD == 0) && (&r_cnt))) begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_id    <= w_id_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= |w_gnt_nx;
    end
  end

  // Overlapping enables would short two gated branches; only meaningful while powered.
  assign w_pwr_ok = VDD & ~VSS;

  always_ff @(posedge CLK) begin
    if (!RST && w_pwr_ok) assert ($onehot0(r_gnt));
  end

  assign GNT    = r_gnt;
  assign GNT_ID = 3'(r_id);
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rr_arb.sv
// Directed bench for the round-robin arbiter: reset, single grant, rotation, wrap,
// reset mid-grant, late requests and unlimited hold (second instance with MAX_HOLD=0).
module tb_gf180mcu_fd_sc_mcu7t5v0__rr_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] req2 = 4'b0000;
  logic [3:0] gnt, gnt2;
  logic [2:0] id, id2;
  logic       busy, busy2;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__rr_arb #(.N(4), .MAX_HOLD(8), .CW(8)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .GNT(gnt), .GNT_ID(id), .BUSY(busy),
    .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__rr_arb #(.N(4), .MAX_HOLD(0), .CW(8)) dut_unl (
    .CLK(clk), .RST(rst), .REQ(req2), .GNT(gnt2), .GNT_ID(id2), .BUSY(busy2),
    .VDD(vdd), .VSS(vss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    req2 = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b busy=%b want gnt=0000 busy=0", gnt, busy);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || id !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b id=%0d busy=%b want 0001/0/1", gnt, id, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || id !== 3'd2 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_cycle%0d: gnt=%b id=%0d busy=%b want 0100/2/1", c, gnt, id, busy);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_gap: gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b1000 || id !== 3'd3) begin
      errors++;
      $display("FAIL single_ptr3: gnt=%b id=%0d want 1000/3", gnt, id);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      exp = 4'b0001 << (s % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        checks++;
        if (gnt !== exp || id !== 3'(s % 4)) begin
          errors++;
          $display("FAIL rotation_slot%0d_cyc%0d: gnt=%b id=%0d want %b/%0d", s, c, gnt, id, exp, s % 4);
        end
      end
      if (s < 4) begin
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rotation_gap%0d: gnt=%b busy=%b want 0000/0", s, gnt, busy);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b1000 || id !== 3'd3) begin
      errors++;
      $display("FAIL wrap_grant3: gnt=%b id=%0d want 1000/3", gnt, id);
    end
    tick();
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_release_gap: gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || id !== 3'd0) begin
      errors++;
      $display("FAIL wrap_grant0: gnt=%b id=%0d want 0001/0", gnt, id);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0010;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0010 || id !== 3'd1) begin
      errors++;
      $display("FAIL midrst_setup: gnt=%b id=%0d want 0010/1", gnt, id);
    end
    rst = 1'b1;
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || id !== 3'd0) begin
      errors++;
      $display("FAIL midrst_ptr0: gnt=%b id=%0d want 0001/0", gnt, id);
    end
  endtask

  task automatic test_late_request();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL late_hold: gnt=%b want 0010", gnt);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL late_gap: gnt=%b want 0000", gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || id !== 3'd0) begin
      errors++;
      $display("FAIL late_grant0: gnt=%b id=%0d want 0001/0", gnt, id);
    end
  endtask

  task automatic test_unlimited_hold();
    logic       ok;
    int         bad_cyc;
    logic [3:0] bad_val;
    do_reset();
    req2    = 4'b0001;
    ok      = 1'b1;
    bad_cyc = 0;
    bad_val = 4'b0000;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (ok && gnt2 !== 4'b0001) begin
        ok      = 1'b0;
        bad_cyc = c;
        bad_val = gnt2;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL unlimited_hold: cycle %0d gnt=%b want 0001", bad_cyc, bad_val);
    end
    req2 = 4'b0000;
    tick();
    checks++;
    if (gnt2 !== 4'b0000 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL unlimited_release: gnt=%b busy=%b want 0000/0", gnt2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_reset_mid_grant();
    test_late_request();
    test_unlimited_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
